// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = PORT0;
    if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie the port that was not served most recently wins
      winner = ~last;
`else
      winner = PORT0;
`endif
    end else if (req1) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port REQ/ACK arbiter and sequencer in front of a single-port registered-read memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: port 0 fixed priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic             RW0,
  input  logic             RW1,
  input  logic [WIDTH-1:0] ADDR0,
  input  logic [WIDTH-1:0] ADDR1,
  input  logic [31:0]      DIN0,
  input  logic [31:0]      DIN1,
  output logic             ACK0,
  output logic             ACK1,
  output logic [31:0]      RDATA0,
  output logic [31:0]      RDATA1,
  output logic             MEM_VALID,
  output logic             MEM_RW,
  output logic [WIDTH-1:0] MEM_ADDR,
  output logic [31:0]      MEM_DIN,
  input  logic [31:0]      MEM_DOUT,
  output logic             BUSY,
  output logic             GRANT
);

  arb_state_e       state_q, state_d;
  logic             mem_valid_q, mem_valid_d;
  logic             mem_rw_q, mem_rw_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]      mem_din_q, mem_din_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             grant_q, grant_d;
  logic             any_req;
  logic             winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  mem_arb_pick u_pick (
    .req0    (REQ0),
    .req1    (REQ1),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last    (last_q),
`endif
    .any_req (any_req),
    .winner  (winner)
  );

  always_comb begin
    state_d     = state_q;
    mem_valid_d = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    busy_d      = busy_q;
    grant_d     = grant_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (any_req) begin
          // The memory pins double as the latch for the granted request
          state_d     = ISSUE;
          grant_d     = winner;
          mem_valid_d = 1'b1;
          mem_rw_d    = winner ? RW1   : RW0;
          mem_addr_d  = winner ? ADDR1 : ADDR0;
          mem_din_d   = winner ? DIN1  : DIN0;
          busy_d      = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d      = winner;
`endif
        end
      end
      ISSUE: begin
        state_d = RESP;
        ack0_d  = (grant_q == PORT0);
        ack1_d  = (grant_q == PORT1);
        busy_d  = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= PORT0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= PORT1;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign MEM_VALID = mem_valid_q;
  assign MEM_RW    = mem_rw_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_DIN   = mem_din_q;
  assign ACK0      = ack0_q;
  assign ACK1      = ack1_q;
  assign BUSY      = busy_q;
  assign GRANT     = grant_q;
  // Memory read data is only present during the ACK cycle of a read
  assign RDATA0    = (ack0_q && !mem_rw_q) ? MEM_DOUT : '0;
  assign RDATA1    = (ack1_q && !mem_rw_q) ? MEM_DOUT : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `MEMORY` block (32-bit words, `2**WIDTH` entries, registered read, synchronous write). It accepts read/write requests from two requesters (port 0 and port 1, e.g. fetch and load/store) over a REQ/ACK handshake. It grants one request at a time, drives the memory's `Valid/RW/Addr/Din` pins for exactly one cycle, and returns read data and an acknowledge to the winner.

## Interface
- `WIDTH`, 8, address width; must match the attached `MEMORY` instance.
- `CLK  in  1`  clock, all state on rising edge.
- `RESET  in  1`  asynchronous, active-high.
- `REQ0 / REQ1  in  1`  request from port n; held high until ACKn.
- `RW0 / RW1  in  1`  1 = write, 0 = read.
- `ADDR0 / ADDR1  in  WIDTH`  word address.
- `DIN0 / DIN1  in  32`  write data.
- `ACK0 / ACK1  out  1`  one-cycle completion pulse for port n.
- `RDATA0 / RDATA1  out  32`  read data; valid only while ACKn=1 for a read.
- `MEM_VALID  out  1`  to memory `Valid`.
- `MEM_RW  out  1`  to memory `RW`.
- `MEM_ADDR  out  WIDTH`  to memory `Addr`.
- `MEM_DIN  out  32`  to memory `Din`.
- `MEM_DOUT  in  32`  from memory `D_OUT`.
- `BUSY  out  1`  high whenever state is not IDLE.
- `GRANT  out  1`  index of the port currently owning the memory; meaningful while BUSY.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If neither REQ is high, stay in IDLE.
  - Otherwise, at the clock edge, pick a winner. The winner's RW/ADDR/DIN are latched into internal registers, GRANT is set, and the FSM goes to ISSUE.
- ISSUE:
  - MEM_VALID=1, with MEM_RW/MEM_ADDR/MEM_DIN taken from the latched registers.
  - The FSM always goes to RESP on the next edge. The memory performs the access at that edge.
- RESP:
  - ACKn=1 for the granted port only.
  - For a read, RDATAn = MEM_DOUT (combinational pass-through).
  - The FSM always goes to IDLE on the next edge.
- Requester inputs are ignored after latching. Changing ADDR/DIN/RW or dropping REQ before ACK does not abort the access; it completes with the latched values.
- A requester must deassert REQ, or present a new request, at the edge that ends its ACK cycle. A REQ still high in IDLE is treated as a new request.
- Tie (both REQ high in IDLE): the winner is decided by the arbitration policy (see Configuration).
- The non-granted requester waits with REQ held; it receives no ACK until it is granted.
- RDATA of the non-acked port is don't-care. The bench may only check it when ACK is high.

## Timing
- Reset values:
  - State IDLE.
  - MEM_VALID=0, MEM_RW=0, MEM_ADDR=0, MEM_DIN=0.
  - ACK0=ACK1=0, BUSY=0, GRANT=0.
  - Round-robin pointer LAST=1.
- Latency: REQ sampled high at edge k gives MEM_VALID high in cycle k..k+1 and ACK high in cycle k+1..k+2. Read and write latency are identical.
- Throughput: one access per 3 cycles; no overlap between accesses.
- MEM_VALID is never high for more than one consecutive cycle.
- RESET asserted mid-operation (ISSUE or RESP) immediately forces IDLE and drops MEM_VALID/ACK. The in-flight access is lost, and the memory contents are cleared by the same RESET.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the port not equal to LAST wins.
  - LAST is updated to the granted port on every grant.
  - The first tie after reset goes to port 0.
- Not defined: fixed priority, port 0 always wins ties. The LAST register is not implemented. Port 1 can starve if port 0 requests continuously.

## Structure
- Shared package `mem_arb_pkg`: FSM state encoding (IDLE/ISSUE/RESP) and port index constants (PORT0=0, PORT1=1).
- One sub-module, `mem_arb_pick`: combinational winner select from REQ0, REQ1 and LAST, with the policy chosen by the macro. The FSM, latches and output muxing stay in `mem_arbiter`.

## Test plan
- Write then read, port 0:
  - REQ0, RW0=1, ADDR0=8'h10, DIN0=32'hDEADBEEF gives ACK0 pulse 2 cycles after the sampling edge, MEM_VALID single-cycle.
  - A following read of 8'h10 gives ACK0 with RDATA0=32'hDEADBEEF.
- Simultaneous reads:
  - REQ0 and REQ1 both high, reading 8'h01 (32'h11) and 8'h02 (32'h22).
  - Round-robin: ACK0/32'h11 first, ACK1/32'h22 3 cycles later. Same order in fixed-priority builds.
- Starvation check, REQ0 and REQ1 held high for 12 cycles:
  - Round-robin: 4 ACKs alternating 0,1,0,1.
  - Fixed priority: 4 ACK0s, no ACK1.
- Input change after grant: ADDR0 changed from 8'h20 to 8'h30 during ISSUE; MEM_ADDR stays 8'h20 and RDATA0 returns mem[8'h20].
- Reset during ISSUE: RESET pulsed while MEM_VALID=1. Outputs return to reset values, no ACK is issued, and a subsequent read of the target address returns 32'h0.
- Idle: no REQ for 10 cycles; BUSY=0, MEM_VALID=0, ACK0=ACK1=0 throughout.
